ad2s1210_register_sequencer: RTL
================================

AD2S1210_REGISTER_SEQUENCER -- requirements
Module: ad2s1210_register_sequencer

Interface
REQ-001 The block SHALL have parameter N_ADDR, default 1, giving the number of register reads per sequence (range 1..8).
REQ-002 The block SHALL have parameter SPI_WIDTH, default 8, giving the SPI word width.
REQ-003 The block SHALL have parameter TIMER_WIDTH, default 16, giving the width of the delay/length counters.
REQ-004 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum cycles spent waiting on any SPI handshake.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: ports clock and reset.
REQ-006 clock  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  single-cycle sequence request.
REQ-009 sample_delay  in  TIMER_WIDTH  idle cycles before first address and before resample.
REQ-010 sample_length  in  TIMER_WIDTH  SAMPLE low-pulse width in cycles.
REQ-011 addresses  in  N_ADDR*8  register addresses, entry 0 in the LSBs.
REQ-012 clear_enable  in  1  perform the second SAMPLE pulse that clears faults.
REQ-013 spi_transfer  axi_stream.master  SPI_WIDTH  words to the SPI engine.
REQ-014 spi_readback  axi_stream.slave  SPI_WIDTH  words returned by the SPI engine.
REQ-015 mode  out  1  1 = configuration mode (A0/A1 driven to config).
REQ-016 sample  out  1  active-low SAMPLE pin.
REQ-017 busy  out  1  sequence in progress.
REQ-018 done  out  1  one-cycle pulse on successful completion.
REQ-019 error  out  1  one-cycle pulse on timeout abort.
REQ-020 read_data  out  N_ADDR*SPI_WIDTH  captured register contents, entry i for addresses[i].

Function
REQ-021 The FSM SHALL have the states IDLE, SAMPLE1, DELAY_ADDR, SEND_ADDR, SEND_READ, WAIT_READ, NEXT, DELAY_RESAMPLE, SAMPLE2, and ABORT.
REQ-022 In IDLE, start SHALL cause sample=0, busy=1 and a move to SAMPLE1; start SHALL be ignored while busy=1.
REQ-023 sample SHALL stay low for exactly max(sample_length,1) cycles in SAMPLE1 and in SAMPLE2.
REQ-024 After SAMPLE1 the block SHALL set sample=1 and mode=1, wait sample_delay cycles in DELAY_ADDR (0 = no wait), then enter SEND_ADDR with index 0.
REQ-025 SEND_ADDR SHALL drive data=addresses[index] with valid=1, held until the cycle valid&ready, after which valid=0 and the FSM moves to SEND_READ.
REQ-026 SEND_READ SHALL send a 0x00 dummy word under the same handshake rule, then move to WAIT_READ.
REQ-027 spi_readback.ready SHALL be 1 in WAIT_READ only; the word received on the first spi_readback valid&ready SHALL be stored into read_data[index], and the FSM SHALL then move to NEXT.
REQ-028 Readback words arriving outside WAIT_READ SHALL be ignored and SHALL not modify read_data.
REQ-029 NEXT SHALL increment index and return to SEND_ADDR when index<N_ADDR-1; otherwise it SHALL go to DELAY_RESAMPLE.
REQ-030 When clear_enable, sampled at start, is 1, DELAY_RESAMPLE SHALL wait sample_delay cycles, then set mode=0 and sample=0 and enter SAMPLE2; on SAMPLE2 expiry the block SHALL set sample=1 and pulse done.
REQ-031 When clear_enable, sampled at start, is 0, the block SHALL set mode=0, pulse done and go to IDLE directly after the final NEXT.
REQ-032 spi_transfer.valid SHALL never drop without a completed handshake except on reset or abort.
REQ-033 A timeout counter SHALL restart on every state entry; if it reaches TIMEOUT in SEND_ADDR, SEND_READ or WAIT_READ, the FSM SHALL enter ABORT.
REQ-034 ABORT SHALL set valid=0, mode=0 and sample=1, pulse error for one cycle and return to IDLE; read_data entries not yet read SHALL keep their previous values.
REQ-035 busy SHALL fall in the same cycle in which done or error is asserted.
REQ-036 Counter comparisons SHALL use TIMER_WIDTH-bit unsigned arithmetic with no wrap-around; the maximum sample_delay is 2^TIMER_WIDTH-1.

Reset
REQ-037 On reset, the block SHALL go to IDLE with sample=1, mode=0, busy=0, done=0, error=0, spi_transfer.valid=0, spi_transfer.data=0, spi_readback.ready=0, read_data=0, index=0 and all counters at 0.
REQ-038 A reset asserted mid-sequence SHALL take effect on the next clock edge, with no done or error pulse.

Structure
REQ-039 The state enum, the 0x00 dummy-read constant and the fault-register address 0xFF SHALL be placed in the shared package ad2s1210_pkg.
REQ-040 A single sub-module, ad2s1210_cycle_timer (load value, start, expired output), SHALL implement the delay, length and timeout counting.

Verification
REQ-041 With N_ADDR=1, addresses=0xFF, sample_length=4, sample_delay=3, clear_enable=1 and ready always 1, readback 0xA5 SHALL give sample low 4 cycles twice, words 0xFF,0x00, read_data=0xA5, and one done pulse.
REQ-042 With N_ADDR=3, addresses={0x91,0x88,0xFF} and readbacks 0x11,0x22,0x33 SHALL give read_data=0x33_22_11 with address order 0xFF,0x88,0x91.
REQ-043 With ready held 0 for 5 cycles in SEND_ADDR, valid SHALL stay 1 and data stable until the handshake, and exactly one word SHALL be transferred.
REQ-044 With TIMEOUT=16 and readback never valid, error SHALL pulse 16 cycles after WAIT_READ entry, with sample=1, mode=0, no done, and read_data unchanged.
REQ-045 clear_enable=0 SHALL produce no second SAMPLE pulse and done one cycle after the readback.
REQ-046 Reset asserted in WAIT_READ, with a second start during busy, SHALL return all outputs to reset values next cycle, and the ignored start SHALL produce no extra sequence.

Source files
------------

// File: rtl/ad2s1210_pkg.sv
// Shared state encoding and SPI constants for the AD2S1210 register sequencer.
package ad2s1210_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SAMPLE1,
        DELAY_ADDR,
        SEND_ADDR,
        SEND_READ,
        WAIT_READ,
        NEXT,
        DELAY_RESAMPLE,
        SAMPLE2,
        ABORT
    } state_t;

    localparam logic [7:0] DUMMY_READ = 8'h00;
    localparam logic [7:0] FAULT_ADDR = 8'hFF;

endpackage

// File: rtl/axi_stream.sv
// Minimal valid/ready/data stream used between the sequencer and the SPI engine.
interface axi_stream #(
    parameter int unsigned WIDTH = 8
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ad2s1210_cycle_timer.sv
// Saturating cycle counter; expired is high in the max(load,1)-th cycle after start.
module ad2s1210_cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || start) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + WIDTH'(1);
        end
    end

    // load of 0 behaves like 1, so the comparison never underflows
    assign expired = (load == '0) || (count >= load - WIDTH'(1));

endmodule

// File: rtl/ad2s1210_register_sequencer.sv
// Drives SAMPLE, reads N_ADDR registers over the SPI stream and optionally re-samples to clear faults.
module ad2s1210_register_sequencer
    import ad2s1210_pkg::*;
#(
    parameter int unsigned N_ADDR      = 1,
    parameter int unsigned SPI_WIDTH   = 8,
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [TIMER_WIDTH-1:0]        sample_delay,
    input  logic [TIMER_WIDTH-1:0]        sample_length,
    input  logic [N_ADDR*8-1:0]           addresses,
    input  logic                          clear_enable,
    axi_stream.master                     spi_transfer,
    axi_stream.slave                      spi_readback,
    output logic                          mode,
    output logic                          sample,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [N_ADDR*SPI_WIDTH-1:0]   read_data
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(TIMEOUT);

    state_t                 state, state_next;
    logic [2:0]             index;
    logic                   clear_q, done_q;
    logic                   last, seq_start, idx_inc, capture, done_set, done_now;
    logic                   timer_start, expired;
    logic [TIMER_WIDTH-1:0] timer_load;
    logic [7:0]             addr_sel;
    logic                   tx_valid, rx_ready;
    logic [SPI_WIDTH-1:0]   tx_data;

    ad2s1210_cycle_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .start   (timer_start),
        .load    (timer_load),
        .expired (expired)
    );

    always_comb begin
        addr_sel = '0;
        for (int unsigned i = 0; i < N_ADDR; i++) begin
            if (index == 3'(i)) addr_sel = addresses[8*i +: 8];
        end
    end

    assign last        = (32'(index) == N_ADDR - 1);
    assign timer_start = (state_next != state);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            read_data <= '0;
        end else begin
            state  <= state_next;
            done_q <= done_set;
            if (seq_start) begin
                index   <= '0;
                clear_q <= clear_enable;
            end else if (idx_inc) begin
                index <= index + 3'd1;
            end
            if (capture) begin
                for (int unsigned i = 0; i < N_ADDR; i++) begin
                    if (index == 3'(i)) read_data[SPI_WIDTH*i +: SPI_WIDTH] <= spi_readback.data;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b1;
        mode       = 1'b0;
        busy       = 1'b1;
        error      = 1'b0;
        done_now   = 1'b0;
        done_set   = 1'b0;
        seq_start  = 1'b0;
        idx_inc    = 1'b0;
        capture    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        rx_ready   = 1'b0;
        timer_load = sample_length;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    seq_start  = 1'b1;
                    state_next = SAMPLE1;
                end
            end
            SAMPLE1: begin
                sample = 1'b0;
                if (expired) state_next = (sample_delay == '0) ? SEND_ADDR : DELAY_ADDR;
            end
            DELAY_ADDR: begin
                mode       = 1'b1;
                timer_load = sample_delay;
                if (expired) state_next = SEND_ADDR;
            end
            SEND_ADDR: begin
                mode       = 1'b1;
                timer_load = TIMEOUT_LOAD;
                tx_valid   = 1'b1;
                tx_data    = SPI_WIDTH'(addr_sel);
                if (spi_transfer.ready) state_next = SEND_READ;
                else if (expired)       state_next = ABORT;
            end
            SEND_READ: begin
                mode       = 1'b1;
                timer_load = TIMEOUT_LOAD;
                tx_valid   = 1'b1;
                tx_data    = SPI_WIDTH'(DUMMY_READ);
                if (spi_transfer.ready) state_next = WAIT_READ;
                else if (expired)       state_next = ABORT;
            end
            WAIT_READ: begin
                mode       = 1'b1;
                timer_load = TIMEOUT_LOAD;
                rx_ready   = 1'b1;
                if (spi_readback.valid) begin
                    capture    = 1'b1;
                    state_next = NEXT;
                end else if (expired) begin
                    state_next = ABORT;
                end
            end
            NEXT: begin
                mode = 1'b1;
                if (!last) begin
                    idx_inc    = 1'b1;
                    state_next = SEND_ADDR;
                end else if (clear_q) begin
                    state_next = (sample_delay == '0) ? SAMPLE2 : DELAY_RESAMPLE;
                end else begin
                    mode       = 1'b0;
                    busy       = 1'b0;
                    done_now   = 1'b1;
                    state_next = IDLE;
                end
            end
            DELAY_RESAMPLE: begin
                mode       = 1'b1;
                timer_load = sample_delay;
                if (expired) state_next = SAMPLE2;
            end
            SAMPLE2: begin
                sample = 1'b0;
                // done is registered here so it lands in the first cycle with SAMPLE released
                if (expired) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            ABORT: begin
                busy       = 1'b0;
                error      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign done               = done_q | done_now;
    assign spi_transfer.valid = tx_valid;
    assign spi_transfer.data  = tx_data;
    assign spi_readback.ready = rx_ready;

endmodule
